// File: rtl/reflet_timer_pkg.sv
// Shared definitions for the reflet_timer peripheral: register indices and bit positions.
package reflet_timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_RELOAD   = 3'd2,
        REG_COUNT    = 3'd3,
        REG_STATUS   = 3'd4
    } reg_idx_e;

    localparam int unsigned NUM_REGS       = 5;
    localparam int unsigned CTRL_W         = 3;
    localparam int unsigned CTRL_RUN       = 0;
    localparam int unsigned CTRL_ONESHOT   = 1;
    localparam int unsigned CTRL_IRQ_EN    = 2;
    localparam int unsigned STATUS_EXPIRED = 0;

    // Byte address of register k for a given base and word stride.
    function automatic int unsigned reg_offset(int unsigned base, int unsigned k,
                                               int unsigned stride);
        return base + k * stride;
    endfunction

endpackage

// File: rtl/reflet_timer_if.sv
// CPU-side bus and interrupt line of the reflet_timer peripheral.
interface reflet_timer_if #(
    parameter int unsigned wordsize = 32
);
    logic [wordsize-1:0] addr;
    logic [wordsize-1:0] data_in;
    logic                write_en;
    logic [wordsize-1:0] data_out;
    logic                interrupt;

    modport master (output addr, data_in, write_en, input data_out, interrupt);
    modport slave  (input addr, data_in, write_en, output data_out, interrupt);
endinterface

// File: rtl/reflet_timer_counter.sv
// Prescaler: emits a one-cycle pulse every 'max' enabled cycles; max=0 never pulses.
module reflet_counter #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [size-1:0] max,
    output logic            pulse
);
    logic [size-1:0] cnt_q, cnt_d;

    // '>=' rather than '==' so a PRESCALE lowered below the current phase wraps at once.
    always_comb begin
        pulse = enable && (max != '0) && (cnt_q >= max - size'(1));
        cnt_d = cnt_q;
        if (enable && (max != '0)) begin
            cnt_d = pulse ? '0 : cnt_q + size'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped down-counting timer with sticky expiry flag, oneshot mode and interrupt.
module reflet_timer
    import reflet_timer_pkg::*;
#(
    parameter int unsigned wordsize  = 32,
    parameter int unsigned base_addr = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    reflet_timer_if.slave  bus
);
    localparam int unsigned STRIDE = wordsize / 8;

    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [wordsize-1:0] prescale_q, prescale_d;
    logic [wordsize-1:0] reload_q, reload_d;
    logic [wordsize-1:0] count_q, count_d;
    logic                expired_q, expired_d;
    logic                hit;
    reg_idx_e            idx;
    logic                tick;
    logic                expire;
    logic [wordsize-1:0] rdata;

    reflet_counter #(.size(wordsize)) u_prescaler (
        .clk    (clk),
        .reset  (!reset),
        .enable (ctrl_q[CTRL_RUN] & enable),
        .max    (prescale_q),
        .pulse  (tick)
    );

    always_comb begin
        hit = 1'b0;
        idx = REG_CTRL;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.addr == wordsize'(reg_offset(base_addr, k, STRIDE))) begin
                hit = 1'b1;
                idx = reg_idx_e'(3'(k));
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (!reset && hit) begin
            case (idx)
                REG_CTRL:     rdata = wordsize'(ctrl_q);
                REG_PRESCALE: rdata = prescale_q;
                REG_RELOAD:   rdata = reload_q;
                REG_COUNT:    rdata = count_q;
                REG_STATUS:   rdata = wordsize'(expired_q);
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.data_out  = rdata;
    assign bus.interrupt = !reset && expired_q && ctrl_q[CTRL_IRQ_EN];

    // Hardware updates first, CPU writes afterwards so a write overrides a same-cycle event.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        expired_d  = expired_q;
        expire     = tick && ctrl_q[CTRL_RUN] && (count_q == '0);

        if (tick && ctrl_q[CTRL_RUN]) begin
            if (count_q != '0) begin
                count_d = count_q - wordsize'(1);
            end else begin
                count_d = reload_q;
                if (ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_RUN] = 1'b0;
            end
        end

        if (bus.write_en && hit) begin
            case (idx)
                REG_CTRL:     ctrl_d = bus.data_in[CTRL_W-1:0];
                REG_PRESCALE: prescale_d = bus.data_in;
                REG_RELOAD: begin
                    reload_d = bus.data_in;
                    count_d  = bus.data_in;
                end
                REG_STATUS:   if (bus.data_in[STATUS_EXPIRED]) expired_d = 1'b0;
                default: ;
            endcase
        end

        if (expire) expired_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
        end
    end
endmodule

// File: tb/tb_reflet_timer.sv
// Self-checking bench for reflet_timer: directed scenarios plus randomized traffic vs. a model.
module tb_reflet_timer;
    logic clk;
    logic reset;
    logic enable;
    int   total;
    int   bad;

    reflet_timer_if #(.wordsize(32)) bus ();

    reflet_timer #(.wordsize(32), .base_addr(0)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state of the peripheral as seen by software.
    logic [2:0]  m_ctrl;
    logic [31:0] m_pre, m_rel, m_cnt;
    bit          m_exp;
    longint      m_phase;

    function automatic int idx_of(logic [31:0] a);
        if (a[1:0] != 2'b00 || a > 32'd16) return -1;
        return int'(a >> 2);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        if (reset) return 32'd0;
        case (idx_of(a))
            0: return {29'd0, m_ctrl};
            1: return m_pre;
            2: return m_rel;
            3: return m_cnt;
            4: return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        logic [2:0]  c;
        logic [31:0] p, r, n;
        bit e, act, tk, set_exp;
        int k;
        if (reset) begin
            m_ctrl = '0; m_pre = '0; m_rel = '0; m_cnt = '0; m_exp = 0; m_phase = 0;
            return;
        end
        c = m_ctrl; p = m_pre; r = m_rel; n = m_cnt; e = m_exp;
        act = enable && m_ctrl[0] && (m_pre != 0);
        tk  = act && (m_phase + 1 >= longint'(m_pre));
        if (act) m_phase = tk ? 0 : m_phase + 1;
        set_exp = tk && (m_cnt == 0);
        if (tk) begin
            if (m_cnt != 0) n = m_cnt - 1;
            else begin
                n = m_rel;
                if (m_ctrl[1]) c[0] = 1'b0;
            end
        end
        k = bus.write_en ? idx_of(bus.addr) : -1;
        case (k)
            0: c = bus.data_in[2:0];
            1: p = bus.data_in;
            2: begin r = bus.data_in; n = bus.data_in; end
            4: if (bus.data_in[0]) e = 0;
            default: ;
        endcase
        if (set_exp) e = 1;
        m_ctrl = c; m_pre = p; m_rel = r; m_cnt = n; m_exp = e;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs mid-cycle.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("data_out", bus.data_out, model_read(bus.addr));
        check("interrupt", {31'd0, bus.interrupt},
              {31'd0, !reset && m_exp && m_ctrl[2]});
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus.addr = a; bus.data_in = d; bus.write_en = 1'b1;
        step();
        bus.write_en = 1'b0;
    endtask

    task automatic rd_chk(string nm, logic [31:0] a, logic [31:0] exp);
        bus.addr = a;
        #1;
        check(nm, bus.data_out, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        step();
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; enable = 1'b1;
        bus.addr = '0; bus.data_in = '0; bus.write_en = 1'b0;
        m_ctrl = '0; m_pre = '0; m_rel = '0; m_cnt = '0; m_exp = 0; m_phase = 0;
        do_reset();
        rd_chk("rst_ctrl", 32'd0, 32'd0);
        rd_chk("rst_count", 32'd12, 32'd0);
        check("rst_irq", {31'd0, bus.interrupt}, 32'd0);

        // Periodic, every tick
        wr(32'd4, 32'd1);
        wr(32'd8, 32'd3);
        wr(32'd0, 32'd5);
        rd_chk("p_cnt3", 32'd12, 32'd3);
        step(); rd_chk("p_cnt2", 32'd12, 32'd2);
        step(); rd_chk("p_cnt1", 32'd12, 32'd1);
        step(); rd_chk("p_cnt0", 32'd12, 32'd0);
        check("p_irq_low", {31'd0, bus.interrupt}, 32'd0);
        step(); check("p_irq_high", {31'd0, bus.interrupt}, 32'd1);
        rd_chk("p_reload", 32'd12, 32'd3);
        wr(32'd16, 32'd1);
        check("w1c_clear", {31'd0, bus.interrupt}, 32'd0);
        rd_chk("p_cnt_after", 32'd12, 32'd2);
        steps(2);
        wr(32'd16, 32'd1);
        check("w1c_vs_set", {31'd0, bus.interrupt}, 32'd1);

        // Oneshot
        do_reset();
        wr(32'd4, 32'd2);
        wr(32'd8, 32'd1);
        wr(32'd0, 32'd7);
        steps(3);
        check("os_irq_early", {31'd0, bus.interrupt}, 32'd0);
        step();
        check("os_irq", {31'd0, bus.interrupt}, 32'd1);
        rd_chk("os_ctrl", 32'd0, 32'd6);
        steps(10);
        rd_chk("os_frozen", 32'd12, 32'd1);

        // No ticks: PRESCALE=0, then global enable low
        do_reset();
        wr(32'd8, 32'd5);
        wr(32'd0, 32'd5);
        steps(50);
        rd_chk("pre0_cnt", 32'd12, 32'd5);
        enable = 1'b0;
        wr(32'd4, 32'd1);
        steps(10);
        rd_chk("en0_cnt", 32'd12, 32'd5);
        check("en0_irq", {31'd0, bus.interrupt}, 32'd0);
        enable = 1'b1;

        // RELOAD write on a tick, ignored COUNT write, unmapped reads
        do_reset();
        wr(32'd4, 32'd1);
        wr(32'd8, 32'd20);
        wr(32'd0, 32'd1);
        steps(3);
        rd_chk("mid_cnt", 32'd12, 32'd17);
        wr(32'd8, 32'd10);
        rd_chk("reload_wins", 32'd12, 32'd10);
        wr(32'd12, 32'd99);
        rd_chk("count_ro", 32'd12, 32'd9);
        rd_chk("unmapped20", 32'd20, 32'd0);
        rd_chk("unaligned", 32'd5, 32'd0);

        // Reset mid-operation
        do_reset();
        wr(32'd4, 32'd1);
        wr(32'd8, 32'd5);
        wr(32'd0, 32'd5);
        steps(6);
        rd_chk("pre_rst_cnt", 32'd12, 32'd5);
        check("pre_rst_irq", {31'd0, bus.interrupt}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_irq_drop", {31'd0, bus.interrupt}, 32'd0);
        check("rst_dout_zero", bus.data_out, 32'd0);
        step();
        reset = 1'b0;
        rd_chk("post_rst_cnt", 32'd12, 32'd0);
        rd_chk("post_rst_status", 32'd16, 32'd0);
        rd_chk("post_rst_pre", 32'd4, 32'd0);
        wr(32'd4, 32'd1);
        wr(32'd8, 32'd2);
        wr(32'd0, 32'd1);
        step();
        rd_chk("restart_cnt", 32'd12, 32'd1);

        // Randomized traffic
        do_reset();
        wr(32'd4, 32'd1);
        wr(32'd8, 32'd3);
        wr(32'd0, 32'd5);
        for (int i = 0; i < 1500; i++) begin
            int r, k;
            logic [31:0] a, d;
            r = int'($urandom_range(0, 199));
            reset  = (r == 0);
            enable = ($urandom_range(0, 9) != 0);
            k = int'($urandom_range(0, 6));
            a = (k < 5) ? 32'(k * 4) : ((k == 5) ? 32'd20 : 32'd6);
            case (k)
                0: d = 32'($urandom_range(0, 7)) | 32'h1;
                1: d = 32'($urandom_range(0, 3));
                2: d = 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            if (($urandom_range(0, 99) < 7) && k == 0) d = 32'($urandom_range(0, 7));
            bus.addr = a;
            bus.data_in = d;
            bus.write_en = (r < 40);
            step();
            bus.write_en = 1'b0;
        end
        reset = 1'b0;
        enable = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation bound exceeded");
        $fatal(1, "timeout");
    end
endmodule
